// File: rtl/rom_port_arbiter.sv
// Shares one instruction-ROM read port between fetch (IF) and load (LS) requesters.
// One word access per cycle; responses return one cycle after the grant.
module rom_port_arbiter #(
  parameter int unsigned ROM_BYTES  = 4096,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        ls_req_i,
  input  logic [31:0] ls_addr_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        rom_en_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i
);

  localparam int unsigned SW        = $clog2(STARVE_MAX + 1);
  localparam logic [31:0] LAST_ADDR = 32'(ROM_BYTES - 4);

  logic [SW-1:0] starve_q, starve_d;
  logic          starve_at_max;
  logic          if_ok, if_win, ls_win, fault;
  logic [31:0]   gnt_addr, load_word;

  // IF response is held in a pending slot so a flush arriving in the response
  // cycle can still suppress it without disturbing the last delivered word.
  logic          if_pend_q, if_pend_err_q;
  logic [31:0]   if_pend_data_q;
  logic [31:0]   if_rdata_q;
  logic          if_err_q;
  logic          if_deliver;

  logic          ls_rvalid_q, ls_err_q;
  logic [31:0]   ls_rdata_q;

  assign starve_at_max = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    if_ok     = if_req_i & ~if_flush_i & ~rst_i;
    ls_win    = ls_req_i & ~rst_i & ~(if_ok & starve_at_max);
    if_win    = if_ok & ~ls_win;
    gnt_addr  = ls_win ? ls_addr_i : if_addr_i;
    fault     = (gnt_addr[1:0] != 2'b00) | (gnt_addr > LAST_ADDR);
    rom_en_o  = (if_win | ls_win) & ~fault;
    rom_addr_o = rom_en_o ? gnt_addr : 32'd0;
    load_word = fault ? 32'd0 : rom_data_i;
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_win) begin
      starve_d = '0;
    end else if (!starve_at_max) begin
      starve_d = SW'(starve_q + 1'b1);
    end
  end

  assign if_gnt_o = if_win;
  assign ls_gnt_o = ls_win;

  assign if_deliver  = if_pend_q & ~if_flush_i;
  assign if_rvalid_o = if_deliver;
  assign if_rdata_o  = if_deliver ? if_pend_data_q : if_rdata_q;
  assign if_err_o    = if_deliver ? if_pend_err_q : if_err_q;

  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_err_o    = ls_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q       <= '0;
      if_pend_q      <= 1'b0;
      if_pend_err_q  <= 1'b0;
      if_pend_data_q <= 32'd0;
      if_rdata_q     <= 32'd0;
      if_err_q       <= 1'b0;
      ls_rvalid_q    <= 1'b0;
      ls_rdata_q     <= 32'd0;
      ls_err_q       <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      if_pend_q <= if_win;
      if (if_win) begin
        if_pend_err_q  <= fault;
        if_pend_data_q <= load_word;
      end
      if (if_deliver) begin
        if_rdata_q <= if_pend_data_q;
        if_err_q   <= if_pend_err_q;
      end
      ls_rvalid_q <= ls_win;
      if (ls_win) begin
        ls_rdata_q <= load_word;
        ls_err_q   <= fault;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: a predictor queues expected responses
// at grant time, an independent monitor pops and checks them one cycle later.
module tb_rom_port_arbiter;
  localparam int RB = 4096;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_addr, ls_rdata;
  logic        rom_en;
  logic [31:0] rom_addr, rom_data;

  rom_port_arbiter #(.ROM_BYTES(RB), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .ls_req_i(ls_req), .ls_addr_i(ls_addr),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata), .ls_err_o(ls_err),
    .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;

  // Byte-wide ROM, big-endian word assembly.
  byte unsigned mem [RB];
  logic [11:0] ra;
  assign ra = rom_addr[11:0] & 12'hFFC;
  assign rom_data = {mem[ra], mem[ra + 12'd1], mem[ra + 12'd2], mem[ra + 12'd3]};

  function automatic logic [31:0] rd(input logic [31:0] a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } rsp_t;
  rsp_t ifq[$];
  rsp_t lsq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int starve = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Predictor: expected grant from the arbitration rules, expected response queued.
  logic        p_ok, e_if, e_ls, e_fault;
  logic [31:0] e_addr;
  always @(negedge clk) begin
    if (rst) begin
      chk1("rst_if_gnt", if_gnt, 1'b0);
      chk1("rst_ls_gnt", ls_gnt, 1'b0);
      chk1("rst_rom_en", rom_en, 1'b0);
      ifq.delete();
      lsq.delete();
      starve = 0;
    end else begin
      p_ok    = if_req && !if_flush;
      e_ls    = ls_req && !(p_ok && starve == SMAX);
      e_if    = p_ok && !e_ls;
      e_addr  = e_ls ? ls_addr : if_addr;
      e_fault = (e_addr[1:0] != 2'b00) || (e_addr > 32'(RB - 4));
      chk1("if_gnt", if_gnt, e_if);
      chk1("ls_gnt", ls_gnt, e_ls);
      chk1("rom_en", rom_en, (e_if || e_ls) && !e_fault);
      if ((e_if || e_ls) && !e_fault) chk32("rom_addr", rom_addr, e_addr);
      if (e_if) ifq.push_back('{cyc + 1, e_fault ? 32'd0 : rd(e_addr), e_fault});
      if (e_ls) lsq.push_back('{cyc + 1, e_fault ? 32'd0 : rd(e_addr), e_fault});
      if (!if_req || e_if) starve = 0;
      else if (starve < SMAX) starve = starve + 1;
    end
  end

  // Monitor: checks rvalid/rdata/err against the queue heads and held values.
  logic [31:0] h_if_data, h_ls_data;
  logic        h_if_err, h_ls_err;
  rsp_t        r;
  always @(negedge clk) begin
    if (rst) begin
      chk1("rst_if_rvalid", if_rvalid, 1'b0);
      chk1("rst_ls_rvalid", ls_rvalid, 1'b0);
      h_if_data = 32'd0; h_if_err = 1'b0;
      h_ls_data = 32'd0; h_ls_err = 1'b0;
    end else begin
      if (ifq.size() > 0 && ifq[0].cyc == cyc) begin
        r = ifq.pop_front();
        if (if_flush) begin
          chk1("if_rvalid_flushed", if_rvalid, 1'b0);
          $display("if rsp cyc=%0d dropped by flush", cyc);
        end else begin
          chk1("if_rvalid", if_rvalid, 1'b1);
          h_if_data = r.data;
          h_if_err  = r.err;
          $display("if rsp cyc=%0d data=%h err=%0b", cyc, if_rdata, if_err);
        end
      end else begin
        chk1("if_rvalid_idle", if_rvalid, 1'b0);
      end
      chk32("if_rdata", if_rdata, h_if_data);
      chk1("if_err", if_err, h_if_err);

      if (lsq.size() > 0 && lsq[0].cyc == cyc) begin
        r = lsq.pop_front();
        chk1("ls_rvalid", ls_rvalid, 1'b1);
        h_ls_data = r.data;
        h_ls_err  = r.err;
        $display("ls rsp cyc=%0d data=%h err=%0b", cyc, ls_rdata, ls_err);
      end else begin
        chk1("ls_rvalid_idle", ls_rvalid, 1'b0);
      end
      chk32("ls_rdata", ls_rdata, h_ls_data);
      chk1("ls_err", ls_err, h_ls_err);
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic fl,
                       input logic lr, input logic [31:0] la);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; if_flush = fl;
    ls_req = lr; ls_addr = la;
  endtask

  function automatic logic [31:0] raddr();
    case ($urandom % 6)
      0, 1, 2: return 32'(($urandom % 1024) * 4);
      3:       return 32'(($urandom % 1024) * 4 + 1 + ($urandom % 3));
      4:       return ($urandom % 2 == 0) ? 32'h0000_0FFC : 32'h0000_1000;
      default: return $urandom;
    endcase
  endfunction

  logic gi, gl;
  initial begin
    for (int i = 0; i < RB; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h4; if_flush = 1'b0;
    ls_req = 1'b1; ls_addr = 32'h8;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // IF alone, back-to-back words
    drive(1, 32'h0, 0, 0, 32'h0);
    drive(1, 32'h4, 0, 0, 32'h0);
    drive(1, 32'h8, 0, 0, 32'h0);
    // both requesting: LS x4 then IF, repeating
    repeat (12) drive(1, 32'h20, 0, 1, 32'h40);
    // LS fault boundaries
    drive(0, 32'h0, 0, 1, 32'h102);
    drive(0, 32'h0, 0, 1, 32'h1000);
    drive(0, 32'h0, 0, 1, 32'hFFC);
    // IF granted then flushed while LS response lands
    drive(1, 32'h10, 0, 0, 32'h0);
    drive(0, 32'h0, 1, 1, 32'h44);
    drive(0, 32'h0, 0, 0, 32'h0);
    // build starvation, grant, then reset the following cycle
    drive(1, 32'h30, 0, 1, 32'h50);
    drive(1, 32'h30, 0, 1, 32'h54);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (7) drive(1, 32'h30, 0, 1, 32'h58);
    drive(0, 32'h0, 0, 0, 32'h0);

    // randomized traffic honouring the hold-until-grant protocol
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      gi = if_gnt;
      gl = ls_gnt;
      @(posedge clk);
      #1;
      if (!if_req || gi) begin
        if_req  = ($urandom % 4) != 0;
        if_addr = raddr();
      end
      if (!ls_req || gl) begin
        ls_req  = ($urandom % 3) != 0;
        ls_addr = raddr();
      end
      if_flush = ($urandom % 8) == 0;
      rst = ($urandom % 300) == 0;
    end

    drive(0, 32'h0, 0, 0, 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ifq.size() + lsq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 responses outstanding", ifq.size() + lsq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
